// File: rtl/ram_bist_ctrl.sv
// Built-in self-test initiator for a single-port synchronous RAM: writes an address-derived
// pattern, reads it back and compares, then repeats with the inverted pattern.
module ram_bist_ctrl #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(8'hA5)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass_ok,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    StIdle, StWr0, StRd0, StChk0, StWr1, StRd1, StChk1, StDone
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    return PATTERN ^ DATA_WIDTH'(a);
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    cmp_valid_q, cmp_valid_d;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q, cmp_addr_d;
  logic [DATA_WIDTH-1:0]   cmp_exp_q, cmp_exp_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_ok_q, pass_ok_d;
  logic                    fail_seen_q, fail_seen_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]   fail_exp_q, fail_exp_d;
  logic [DATA_WIDTH-1:0]   fail_got_q, fail_got_d;
  logic                    mismatch;
  logic                    accept;

  // The compare always targets the read issued on the previous cycle.
  assign mismatch = cmp_valid_q && (ram_rdata != cmp_exp_q);
  assign accept   = start && ((state_q == StIdle) || ((state_q == StDone) && done_q));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cmp_valid_d = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    cmp_exp_d   = cmp_exp_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_ok_d   = pass_ok_q;
    fail_seen_d = fail_seen_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    if (accept) begin
      state_d     = StWr0;
      addr_d      = '0;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      pass_ok_d   = 1'b0;
      fail_seen_d = 1'b0;
      fail_addr_d = '0;
      fail_exp_d  = '0;
      fail_got_d  = '0;
    end else if (mismatch) begin
      // Abort: the read that would have been issued this cycle is suppressed.
      state_d     = StDone;
      addr_d      = '0;
      fail_seen_d = 1'b1;
      fail_addr_d = cmp_addr_q;
      fail_exp_d  = cmp_exp_q;
      fail_got_d  = ram_rdata;
    end else begin
      unique case (state_q)
        StWr0, StWr1: begin
          ram_we    = 1'b1;
          ram_addr  = addr_q;
          ram_wdata = (state_q == StWr0) ? pat(addr_q) : ~pat(addr_q);
          addr_d    = addr_q + 1'b1;
          if (addr_q == AddrMax) begin
            state_d = (state_q == StWr0) ? StRd0 : StRd1;
            addr_d  = (state_q == StWr0) ? '0 : AddrMax;
          end
        end
        StRd0: begin
          ram_re      = 1'b1;
          ram_addr    = addr_q;
          cmp_valid_d = 1'b1;
          cmp_addr_d  = addr_q;
          cmp_exp_d   = pat(addr_q);
          addr_d      = addr_q + 1'b1;
          if (addr_q == AddrMax) state_d = StChk0;
        end
        StRd1: begin
          ram_re      = 1'b1;
          ram_addr    = addr_q;
          cmp_valid_d = 1'b1;
          cmp_addr_d  = addr_q;
          cmp_exp_d   = ~pat(addr_q);
          addr_d      = addr_q - 1'b1;
          if (addr_q == '0) begin
            state_d = StChk1;
            addr_d  = '0;
          end
        end
        StChk0: state_d = StWr1;
        StChk1: state_d = StDone;
        StDone: begin
          // Report one cycle after entering DONE; start is only honoured once reported.
          if (!done_q) begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            pass_ok_d = !fail_seen_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_ok_q   <= 1'b0;
      fail_seen_q <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_ok_q   <= pass_ok_d;
      fail_seen_q <= fail_seen_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_ok   = pass_ok_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: default instance plus a small 3-bit/4-bit instance,
// each wired to a behavioural 1-cycle-latency RAM with optional fault injection.
module tb_ram_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance (N=16, 8-bit)
  logic       start_a = 1'b0;
  logic       busy_a, done_a, pass_ok_a, we_a, re_a;
  logic [3:0] fail_addr_a, addr_a;
  logic [7:0] fail_exp_a, fail_got_a, wdata_a, rdata_a, rd_model_a;
  logic [7:0] mem_a [16];
  logic       fault_stuck = 1'b0;
  logic       fault_p1    = 1'b0;

  ram_bist_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .pass_ok(pass_ok_a),
    .fail_addr(fail_addr_a), .fail_exp(fail_exp_a), .fail_got(fail_got_a),
    .ram_we(we_a), .ram_re(re_a), .ram_addr(addr_a), .ram_wdata(wdata_a), .ram_rdata(rdata_a)
  );

  always_comb begin
    rd_model_a = mem_a[addr_a];
    if (fault_stuck && addr_a == 4'd5) rd_model_a[0] = 1'b1;
    if (fault_p1 && addr_a == 4'd3 && mem_a[addr_a] == 8'h59) rd_model_a = 8'h00;
  end

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= wdata_a;
    if (re_a) rdata_a <= rd_model_a;
  end

  // Small instance (N=8, 4-bit, PATTERN=F)
  logic       start_b = 1'b0;
  logic       busy_b, done_b, pass_ok_b, we_b, re_b;
  logic [2:0] fail_addr_b, addr_b;
  logic [3:0] fail_exp_b, fail_got_b, wdata_b, rdata_b;
  logic [3:0] mem_b [8];

  ram_bist_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(3), .PATTERN(4'hF)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass_ok(pass_ok_b),
    .fail_addr(fail_addr_b), .fail_exp(fail_exp_b), .fail_got(fail_got_b),
    .ram_we(we_b), .ram_re(re_b), .ram_addr(addr_b), .ram_wdata(wdata_b), .ram_rdata(rdata_b)
  );

  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= wdata_b;
    if (re_b) rdata_b <= mem_b[addr_b];
  end

  // Access logs, sampled mid-cycle
  int wq[$];
  int wdq[$];
  int rq[$];
  int rq_b[$];
  int overlap_a = 0;
  int overlap_b = 0;
  int wdata_bad = 0;

  always @(negedge clk) begin
    if (we_a && re_a) overlap_a++;
    if (!we_a && wdata_a != 8'h00) wdata_bad++;
    if (we_a) begin
      wq.push_back(int'(addr_a));
      wdq.push_back(int'(wdata_a));
    end
    if (re_a) rq.push_back(int'(addr_a));
    if (we_b && re_b) overlap_b++;
    if (re_b) rq_b.push_back(int'(addr_b));
  end

  task automatic clear_logs();
    wq.delete(); wdq.delete(); rq.delete(); rq_b.delete();
    overlap_a = 0; overlap_b = 0; wdata_bad = 0;
  endtask

  // Pulse start on instance A; edges counts clock edges after the start edge until done.
  task automatic run_a(output int edges);
    clear_logs();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    edges = 0;
    while (!done_a && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_a, done_a, pass_ok_a, we_a, re_a} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 00000", {busy_a, done_a, pass_ok_a, we_a, re_a});
    end
    checks++;
    if ({fail_addr_a, fail_exp_a, fail_got_a, addr_a, wdata_a} !== 36'h0) begin
      errors++; $display("FAIL reset_data: got %h required 0",
                         {fail_addr_a, fail_exp_a, fail_got_a, addr_a, wdata_a});
    end
  endtask

  task automatic test_pass();
    int edges;
    int bad_order;
    run_a(edges);
    checks++;
    if (edges !== 67) begin errors++; $display("FAIL pass_done_edge: got %0d required 67", edges); end
    checks++;
    if (pass_ok_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL pass_ok: got pass_ok=%b busy=%b required 1 0", pass_ok_a, busy_a);
    end
    checks++;
    if ({fail_addr_a, fail_exp_a, fail_got_a} !== 20'h0) begin
      errors++; $display("FAIL pass_fail_fields: got %h required 0", {fail_addr_a, fail_exp_a, fail_got_a});
    end
    checks++;
    if (wq.size() !== 32 || rq.size() !== 32) begin
      errors++; $display("FAIL pass_counts: got w=%0d r=%0d required 32 32", wq.size(), rq.size());
    end else begin
      checks++;
      if (wdq[0] !== 'hA5 || wdq[1] !== 'hA4 || wdq[2] !== 'hA7 || wdq[16] !== 'h5A) begin
        errors++; $display("FAIL pass_wdata: got %h %h %h %h required a5 a4 a7 5a",
                           wdq[0], wdq[1], wdq[2], wdq[16]);
      end
      bad_order = 0;
      for (int i = 0; i < 32; i++) if (wq[i] != i % 16) bad_order++;
      for (int i = 0; i < 16; i++) if (rq[i] != i || rq[16 + i] != 15 - i) bad_order++;
      checks++;
      if (bad_order !== 0) begin
        errors++; $display("FAIL pass_addr_order: got %0d bad slots required 0", bad_order);
      end
    end
    checks++;
    if (overlap_a !== 0 || wdata_bad !== 0) begin
      errors++; $display("FAIL pass_we_re: got overlap=%0d wdata_bad=%0d required 0 0", overlap_a, wdata_bad);
    end
  endtask

  task automatic test_stuck_rd0();
    int edges;
    fault_stuck = 1'b1;
    run_a(edges);
    fault_stuck = 1'b0;
    checks++;
    if (done_a !== 1'b1 || pass_ok_a !== 1'b0) begin
      errors++; $display("FAIL stuck_status: got done=%b pass_ok=%b required 1 0", done_a, pass_ok_a);
    end
    checks++;
    if (fail_addr_a !== 4'd5 || fail_exp_a !== 8'hA0 || fail_got_a !== 8'hA1) begin
      errors++; $display("FAIL stuck_fields: got %h/%h/%h required 5/a0/a1", fail_addr_a, fail_exp_a, fail_got_a);
    end
    checks++;
    if (wq.size() !== 16 || rq.size() !== 6) begin
      errors++; $display("FAIL stuck_accesses: got w=%0d r=%0d required 16 6", wq.size(), rq.size());
    end
  endtask

  task automatic test_fault_pass1();
    int edges;
    fault_p1 = 1'b1;
    run_a(edges);
    fault_p1 = 1'b0;
    checks++;
    if (done_a !== 1'b1 || pass_ok_a !== 1'b0) begin
      errors++; $display("FAIL p1_status: got done=%b pass_ok=%b required 1 0", done_a, pass_ok_a);
    end
    checks++;
    if (fail_addr_a !== 4'd3 || fail_exp_a !== 8'h59 || fail_got_a !== 8'h00) begin
      errors++; $display("FAIL p1_fields: got %h/%h/%h required 3/59/00", fail_addr_a, fail_exp_a, fail_got_a);
    end
    checks++;
    if (rq.size() !== 29) begin
      errors++; $display("FAIL p1_read_count: got %0d required 29", rq.size());
    end else begin
      checks++;
      if (rq[16] !== 15 || rq[28] !== 3) begin
        errors++; $display("FAIL p1_rd1_order: got first=%0d last=%0d required 15 3", rq[16], rq[28]);
      end
    end
  endtask

  // Restart from a failed DONE with start held high for the whole run.
  task automatic test_restart_held();
    int edges;
    clear_logs();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy_a, done_a, pass_ok_a} !== 3'b100) begin
      errors++; $display("FAIL restart_status: got %b required 100", {busy_a, done_a, pass_ok_a});
    end
    checks++;
    if ({fail_addr_a, fail_exp_a, fail_got_a} !== 20'h0) begin
      errors++; $display("FAIL restart_clear: got %h required 0", {fail_addr_a, fail_exp_a, fail_got_a});
    end
    edges = 0;
    while (!done_a && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    start_a = 1'b0;
    checks++;
    if (edges !== 67 || pass_ok_a !== 1'b1) begin
      errors++; $display("FAIL held_start_timing: got edge=%0d pass_ok=%b required 67 1", edges, pass_ok_a);
    end
    checks++;
    if (wq.size() !== 32) begin
      errors++; $display("FAIL held_start_writes: got %0d required 32", wq.size());
    end
  endtask

  task automatic test_reset_mid_wr1();
    int edges;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    checks++;
    if (we_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++; $display("FAIL midwr1_active: got we=%b busy=%b required 1 1", we_a, busy_a);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({we_a, re_a, busy_a, done_a} !== 4'b0) begin
      errors++; $display("FAIL midwr1_async_reset: got %b required 0000", {we_a, re_a, busy_a, done_a});
    end
    @(posedge clk); #1 rst = 1'b1;
    run_a(edges);
    checks++;
    if (edges !== 67 || pass_ok_a !== 1'b1) begin
      errors++; $display("FAIL midwr1_rerun: got edge=%0d pass_ok=%b required 67 1", edges, pass_ok_a);
    end
  endtask

  task automatic test_small_params();
    int edges;
    int bad_order;
    clear_logs();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    edges = 0;
    while (!done_b && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges !== 35 || pass_ok_b !== 1'b1) begin
      errors++; $display("FAIL small_done: got edge=%0d pass_ok=%b required 35 1", edges, pass_ok_b);
    end
    checks++;
    if (rq_b.size() !== 16) begin
      errors++; $display("FAIL small_reads: got %0d required 16", rq_b.size());
    end else begin
      bad_order = 0;
      for (int i = 0; i < 8; i++) if (rq_b[8 + i] != 7 - i) bad_order++;
      checks++;
      if (bad_order !== 0) begin
        errors++; $display("FAIL small_rd1_order: got %0d bad slots required 0", bad_order);
      end
    end
    checks++;
    if (overlap_b !== 0) begin
      errors++; $display("FAIL small_we_re: got %0d required 0", overlap_b);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    test_pass();
    test_stuck_rd0();
    test_fault_pass1();
    test_restart_held();
    test_reset_mid_wr1();
    test_small_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
